// File: rtl/ex_fwd_mdu.sv
// rtl/ex_fwd_mdu.sv - EX-stage operand forwarding with iterative RV32M multiply/divide unit
module ex_fwd_mdu #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        ex_adv,
  input  logic [4:0]                  rs1,
  input  logic [4:0]                  rs2,
  input  logic [XLEN-1:0]             rdata1,
  input  logic [XLEN-1:0]             rdata2,
  input  logic [NUM_FWD*(XLEN+6)-1:0] fwd_bus,
  input  logic                        md_req,
  input  logic [2:0]                  md_funct,
  output logic [XLEN-1:0]             src1,
  output logic [XLEN-1:0]             src2,
  output logic [XLEN-1:0]             md_result,
  output logic                        md_done,
  output logic                        stallreq_ex
);
  localparam int FWD_WD = XLEN + 6;
  localparam int CNT_W  = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [XLEN-1:0]     op_b;
  logic [2*XLEN-1:0]   acc;
  logic                is_div, sel_hi, neg_res, neg_rem;

  // Walk from the farthest source down so the nearest matching stage wins.
  always_comb begin
    src1 = rdata1;
    src2 = rdata2;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_bus[k*FWD_WD + XLEN + 5] && fwd_bus[k*FWD_WD + XLEN +: 5] == rs1 && rs1 != 5'd0)
        src1 = fwd_bus[k*FWD_WD +: XLEN];
      if (fwd_bus[k*FWD_WD + XLEN + 5] && fwd_bus[k*FWD_WD + XLEN +: 5] == rs2 && rs2 != 5'd0)
        src2 = fwd_bus[k*FWD_WD +: XLEN];
    end
  end

  logic            signed_a, signed_b, a_neg, b_neg, div_zero, div_ovf, special, last;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    signed_a = md_funct[2] ? !md_funct[0] : (md_funct[1:0] == 2'b01 || md_funct[1:0] == 2'b10);
    signed_b = md_funct[2] ? !md_funct[0] : (md_funct[1:0] == 2'b01);
    a_neg    = signed_a && src1[XLEN-1];
    b_neg    = signed_b && src2[XLEN-1];
    a_mag    = a_neg ? -src1 : src1;
    b_mag    = b_neg ? -src2 : src2;
    div_zero = md_funct[2] && (src2 == '0);
    div_ovf  = md_funct[2] && !md_funct[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    special  = div_zero || div_ovf;
    last     = (cnt == CNT_W'(XLEN - 1));
  end

  // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] step, prod_fix;
  logic [XLEN-1:0]   quo, rem, fix_result;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_b} : '0);
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, op_b};
    if (is_div)
      step = {(div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0]), acc[XLEN-2:0], ~div_diff[XLEN]};
    else
      step = {mul_sum, acc[XLEN-1:1]};
    prod_fix = neg_res ? -step : step;
    quo      = step[XLEN-1:0];
    rem      = step[2*XLEN-1:XLEN];
    if (is_div)
      fix_result = sel_hi ? (neg_rem ? -rem : rem) : (neg_res ? -quo : quo);
    else
      fix_result = sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (md_req) state_nxt = special ? S_DONE : S_BUSY;
      S_BUSY:  if (last) state_nxt = S_DONE;
      S_DONE:  if (ex_adv) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      op_b      <= '0;
      acc       <= '0;
      is_div    <= 1'b0;
      sel_hi    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      md_result <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (md_req) begin
          op_b    <= b_mag;
          acc     <= {{XLEN{1'b0}}, a_mag};
          is_div  <= md_funct[2];
          sel_hi  <= md_funct[2] ? md_funct[1] : (md_funct[1:0] != 2'b00);
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          cnt     <= '0;
          if (div_zero)     md_result <= md_funct[1] ? src1 : '1;
          else if (div_ovf) md_result <= md_funct[1] ? '0 : src1;
        end
        S_BUSY: begin
          acc <= step;
          if (last) md_result <= fix_result;
          else      cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign md_done     = (state == S_DONE);
  assign stallreq_ex = md_req && !flush && (state != S_DONE);
endmodule

// File: tb/tb_ex_fwd_mdu.sv
// tb/tb_ex_fwd_mdu.sv - table-driven self-checking bench for ex_fwd_mdu
module tb_ex_fwd_mdu;
  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int FWD_WD  = XLEN + 6;

  logic                      clk = 1'b0;
  logic                      rst_n, flush, ex_adv, md_req;
  logic [4:0]                rs1, rs2;
  logic [XLEN-1:0]           rdata1, rdata2;
  logic [NUM_FWD*FWD_WD-1:0] fwd_bus;
  logic [2:0]                md_funct;
  logic [XLEN-1:0]           src1, src2, md_result;
  logic                      md_done, stallreq_ex;

  int checks   = 0;
  int failures = 0;

  ex_fwd_mdu #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ex_adv(ex_adv),
    .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2), .fwd_bus(fwd_bus),
    .md_req(md_req), .md_funct(md_funct),
    .src1(src1), .src2(src2), .md_result(md_result), .md_done(md_done), .stallreq_ex(stallreq_ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]                rs1, rs2;
    logic [XLEN-1:0]           rd1, rd2;
    logic [NUM_FWD*FWD_WD-1:0] fwd;
    logic [XLEN-1:0]           e1, e2;
  } fwd_vec_t;

  typedef struct {
    logic [2:0]      fn;
    logic [XLEN-1:0] a, b, exp;
    int              lat;
  } md_vec_t;

  function automatic logic [NUM_FWD*FWD_WD-1:0] fb(input logic we0, input logic [4:0] a0,
      input logic [XLEN-1:0] d0, input logic we1, input logic [4:0] a1, input logic [XLEN-1:0] d1);
    return {we1, a1, d1, we0, a0, d0};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=0x%08h required=0x%08h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_md(input int idx, input logic [2:0] fn, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
    int cyc, stl;
    rs1 = 5'd1; rs2 = 5'd2; fwd_bus = '0; rdata1 = a; rdata2 = b;
    md_funct = fn; md_req = 1'b1; ex_adv = 1'b0;
    #1;
    cyc = 0; stl = 0;
    while (!md_done && cyc < 100) begin
      if (stallreq_ex) stl++;
      tick();
      cyc++;
    end
    chk("md_latency", idx, 32'(cyc), 32'(lat));
    chk("md_stall_cycles", idx, 32'(stl), 32'(lat));
    chk("md_result", idx, md_result, exp);
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("hold_done", idx, 32'(md_done), 32'd1);
      chk("hold_result", idx, md_result, exp);
      chk("hold_stall", idx, 32'(stallreq_ex), 32'd0);
    end
    ex_adv = 1'b1;
    tick();
    md_req = 1'b0; ex_adv = 1'b0;
    #1;
    chk("release_done", idx, 32'(md_done), 32'd0);
  endtask

  fwd_vec_t fv[4];
  md_vec_t  mv[14];

  initial begin
    fv[0] = '{5'd5, 5'd3, 32'h1111_1111, 32'h2222_2222, fb(1'b1, 5'd5, 32'hAAAA_0000, 1'b1, 5'd5, 32'hBBBB_0000), 32'hAAAA_0000, 32'h2222_2222};
    fv[1] = '{5'd0, 5'd6, 32'h3333_3333, 32'h4444_4444, fb(1'b1, 5'd0, 32'hDEAD_0000, 1'b1, 5'd6, 32'hCAFE_0006), 32'h3333_3333, 32'hCAFE_0006};
    fv[2] = '{5'd7, 5'd7, 32'h5555_5555, 32'h6666_6666, fb(1'b0, 5'd7, 32'h0BAD_0007, 1'b1, 5'd7, 32'h600D_0007), 32'h600D_0007, 32'h600D_0007};
    fv[3] = '{5'd9, 5'd9, 32'h7777_7777, 32'h8888_8888, fb(1'b0, 5'd9, 32'h1234_5678, 1'b0, 5'd9, 32'h8765_4321), 32'h7777_7777, 32'h8888_8888};

    mv[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    mv[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    mv[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    mv[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
    mv[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    mv[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    mv[6]  = '{3'b101, 32'd7,          32'd0,         32'hFFFF_FFFF, 1};
    mv[7]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    mv[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    mv[9]  = '{3'b111, 32'd100,        32'd7,         32'd2,         33};
    mv[10] = '{3'b110, 32'd5,          32'd0,         32'd5,         1};
    mv[11] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    mv[12] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         33};
    mv[13] = '{3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33};

    rst_n = 1'b0; flush = 1'b0; ex_adv = 1'b0; md_req = 1'b0; md_funct = 3'b000;
    rs1 = 5'd0; rs2 = 5'd0; rdata1 = '0; rdata2 = '0; fwd_bus = '0;
    tick(); tick();
    chk("reset_done", 0, 32'(md_done), 32'd0);
    chk("reset_result", 0, md_result, 32'd0);
    chk("reset_stall", 0, 32'(stallreq_ex), 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (fv[i]) begin
      rs1 = fv[i].rs1; rs2 = fv[i].rs2; rdata1 = fv[i].rd1; rdata2 = fv[i].rd2; fwd_bus = fv[i].fwd;
      #1;
      chk("fwd_src1", i, src1, fv[i].e1);
      chk("fwd_src2", i, src2, fv[i].e2);
      chk("fwd_idle_stall", i, 32'(stallreq_ex), 32'd0);
      tick();
    end

    foreach (mv[i]) run_md(i, mv[i].fn, mv[i].a, mv[i].b, mv[i].exp, mv[i].lat);

    // Flush while BUSY at cnt=10, then a fresh MUL must take the full latency.
    rs1 = 5'd1; rs2 = 5'd2; fwd_bus = '0; rdata1 = 32'd6; rdata2 = 32'd7;
    md_funct = 3'b000; md_req = 1'b1;
    repeat (11) tick();
    flush = 1'b1;
    #1;
    chk("flush_stall", 0, 32'(stallreq_ex), 32'd0);
    tick();
    flush = 1'b0; md_req = 1'b0;
    #1;
    chk("flush_done", 0, 32'(md_done), 32'd0);
    chk("flush_idle_stall", 0, 32'(stallreq_ex), 32'd0);
    tick();
    run_md(100, 3'b000, 32'd100, 32'd3, 32'd300, 33);

    // Operands must be latched: disturb rdata and forwarding mid-operation.
    rs1 = 5'd1; rs2 = 5'd2; fwd_bus = '0; rdata1 = 32'd100; rdata2 = 32'd7;
    md_funct = 3'b101; md_req = 1'b1;
    repeat (5) tick();
    rdata1 = 32'd999; rdata2 = 32'd3;
    fwd_bus = fb(1'b1, 5'd1, 32'd50, 1'b1, 5'd2, 32'd5);
    begin
      int cyc;
      cyc = 5;
      while (!md_done && cyc < 100) begin
        tick();
        cyc++;
      end
      chk("latch_latency", 0, 32'(cyc), 32'd33);
      chk("latch_result", 0, md_result, 32'd14);
    end
    ex_adv = 1'b1;
    tick();
    md_req = 1'b0; ex_adv = 1'b0; fwd_bus = '0;
    tick();

    // Reset mid-operation discards the result.
    rdata1 = 32'd9; rdata2 = 32'd9; md_funct = 3'b000; md_req = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0; md_req = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_done", 0, 32'(md_done), 32'd0);
    chk("midrst_result", 0, md_result, 32'd0);
    tick();
    run_md(101, 3'b011, 32'd9, 32'd9, 32'd0, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
